fa_bist: RTL
============

Name: fa_bist

Overview:
- Built-in self-test engine for a 1-bit full adder: the response/checking end of the full-adder stimulus interface.
- Drives all 8 {In1,In2,Cin} vectors into an external full adder and samples Sum/Cout after a settle window.
- Compares each sample against the expected sum and carry, counts mismatches and reports pass/fail.
- Sits beside a FullAdder instance on the lab board; the sweep is triggered by a pushbutton or by a bench.

Parameters:
SETTLE_CYCLES, 2, cycles a vector is held before sampling; legal range is >= 1.
PASSES, 1, number of full 8-vector sweeps per run; legal range is >= 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request to begin a run; sampled only in IDLE or DONE.
dut_in1  out  1  full adder In1; MSB of the vector.
dut_in2  out  1  full adder In2.
dut_cin  out  1  full adder Cin; LSB of the vector.
dut_sum  in  1  full adder Sum.
dut_cout  in  1  full adder Cout.
busy  out  1  high while a run is in progress.
done  out  1  high in DONE; held until the next start or reset.
pass  out  1  done && err_count==0.
err_count  out  4  number of mismatching vectors, saturating at 15.
first_fail_vec  out  3  {In1,In2,Cin} of the first mismatch in the run.
first_fail_valid  out  1  first_fail_vec holds a capture.
fail_map  out  8  bit v set if vector v ever failed (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: dut_* = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail_vec = 0, first_fail_valid = 0, fail_map = 0.
- Internal state: vec[2:0], settle counter, pass counter. dut_{in1,in2,cin} = vec, registered.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE, start = 1:
  - Go to SETTLE; vec = 0; settle and pass counters = 0.
  - Clear err_count, first_fail_*, fail_map and done.
- SETTLE:
  - Settle counter increments each cycle.
  - At counter == SETTLE_CYCLES-1, go to CHECK.
- CHECK:
  - Expected sum = ^vec; expected cout = majority(vec).
  - A mismatch on either bit counts as one error for the vector: err_count += 1, saturating at 15.
  - On a mismatch with first_fail_valid = 0: capture vec into first_fail_vec and set first_fail_valid.
  - If vec == 7 and this is the last pass, go to DONE.
  - Otherwise vec wraps 7 -> 0, the pass counter increments on that wrap, the settle counter clears, and the FSM returns to SETTLE.
- Timing: each vector takes SETTLE_CYCLES+1 cycles.
  - If start is sampled at edge k, busy = 1 from edge k.
  - done = 1 and busy = 0 from edge k + 8*(SETTLE_CYCLES+1)*PASSES.
- DONE: dut_* return to 000. Results are held.
- start while busy: ignored.
- start in DONE: a new run begins; results clear on that edge.
- Reset mid-run: aborts immediately to the reset values above; no partial result is retained.
- pass is combinational from done and err_count.

Optional Feature:
- Macro FA_BIST_FAIL_MAP_EN.
- Defined: fail_map[v] sets in CHECK on a mismatch at vec == v and is sticky across passes. It clears on start or reset.
- Undefined: fail_map is tied to 8'h00 and no map registers are built; all other behaviour is unchanged.

Test Plan:
- Correct full adder model, defaults, start pulse at edge 10 -> done at edge 34, pass = 1, err_count = 0, first_fail_valid = 0, fail_map = 8'h00.
- dut_sum stuck at 0 -> err_count = 4, first_fail_vec = 3'b001, pass = 0. With FA_BIST_FAIL_MAP_EN defined: fail_map = 8'h96.
- dut_cout inverted, PASSES = 3 -> err_count = 15 (24 mismatches, saturated), first_fail_vec = 3'b000, done at start edge + 72.
- Monitor dut_* during a correct run with SETTLE_CYCLES = 1 -> vectors 000..111 in order, each held 2 cycles. A second start pulse at mid-run is ignored: busy stays high and done timing is unchanged.
- rst_n low for 1 cycle at mid-run -> all outputs 0 asynchronously. A fresh start then gives a full pass with correct timing.
- Start in DONE after a failing run, DUT now correct -> results clear on the start edge and the run ends with pass = 1.

Source files
------------

// File: rtl/fa_bist.sv
// Built-in self-test engine for a 1-bit full adder: sweeps all 8 input vectors and checks Sum/Cout.
// Optional build macro FA_BIST_FAIL_MAP_EN adds a per-vector sticky failure map.
module fa_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_cin,
    input  logic       dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [7:0] fail_map
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    vec_q, vec_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    err_q, err_d;
    logic [2:0]    ffvec_q, ffvec_d;
    logic          ffvalid_q, ffvalid_d;

    logic launch;
    logic exp_sum;
    logic exp_cout;
    logic mismatch;

    assign launch   = start && ((state_q == IDLE) || (state_q == DONE));
    assign exp_sum  = ^vec_q;
    assign exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    assign mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= 3'd0;
            scnt_q    <= '0;
            pcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 4'd0;
            ffvec_q   <= 3'd0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            scnt_q    <= scnt_d;
            pcnt_q    <= pcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // Next-state and next-result logic
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        scnt_d    = scnt_q;
        pcnt_d    = pcnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d   = SETTLE;
                    vec_d     = 3'd0;
                    scnt_d    = '0;
                    pcnt_d    = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 4'd0;
                    ffvec_d   = 3'd0;
                    ffvalid_d = 1'b0;
                end
            end
            SETTLE: begin
                scnt_d = scnt_q + SW'(1);
                if (scnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != 4'hF) begin
                        err_d = err_q + 4'd1;
                    end
                    if (!ffvalid_q) begin
                        ffvec_d   = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if ((vec_q == 3'd7) && (pcnt_q == PASS_LAST)) begin
                    state_d = DONE;
                    vec_d   = 3'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 3'd1;
                    scnt_d  = '0;
                    if (vec_q == 3'd7) begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FA_BIST_FAIL_MAP_EN
    logic [7:0] map_q, map_d;

    // Sticky per-vector failure map, cleared when a run is launched
    always_comb begin
        map_d = map_q;
        if (launch) begin
            map_d = 8'h00;
        end else if ((state_q == CHECK) && mismatch) begin
            map_d = map_q | (8'h01 << vec_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= 8'h00;
        end else begin
            map_q <= map_d;
        end
    end

    assign fail_map = map_q;
`else
    assign fail_map = 8'h00;
`endif

    assign {dut_in1, dut_in2, dut_cin} = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = done_q && (err_q == 4'd0);
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffvalid_q;

endmodule
